// File: rtl/tile_cfg_deserializer_pkg.sv
// Shared configuration-chain definitions: frame geometry and receiver state encoding.
// The frame length is the tile config size plus its ID field, rounded up to a whole number of 32-bit words.
package tile_cfg_deserializer_pkg;

    localparam int CFG_ID_WIDTH   = 3;
    localparam int CFG_SIZE       = 61;
    localparam int CFG_FRAME_BITS = ((CFG_SIZE + CFG_ID_WIDTH + 31) / 32) * 32;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/tile_cfg_deserializer_chain_pipe.sv
// One register stage of the column config chain (start, bit, valid).
// Kept separate so IO tiles can reuse the same forwarding stage.
module cfg_chain_pipe (
    input  logic clk,
    input  logic rst,
    input  logic cfg_start,
    input  logic cfg_bit,
    input  logic cfg_valid,
    output logic fwd_start,
    output logic fwd_bit,
    output logic fwd_valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_start <= 1'b0;
            fwd_bit   <= 1'b0;
            fwd_valid <= 1'b0;
        end else begin
            fwd_start <= cfg_start;
            fwd_bit   <= cfg_bit;
            fwd_valid <= cfg_valid;
        end
    end

endmodule

// File: rtl/tile_cfg_deserializer.sv
// Tile-side receiver of the serial config chain: deserializes LSB-first frames,
// commits the payload when the frame ID matches the strapped tile ID, and forwards the chain.
module tile_cfg_deserializer
    import tile_cfg_deserializer_pkg::*;
#(
    parameter int ID_WIDTH   = CFG_ID_WIDTH,
    parameter int FRAME_BITS = CFG_FRAME_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [ID_WIDTH-1:0]            tile_id,
    input  logic                           cfg_in_start,
    input  logic                           cfg_bit_in,
    input  logic                           cfg_bit_in_valid,
    output logic                           cfg_out_start,
    output logic                           cfg_bit_out,
    output logic                           cfg_bit_out_valid,
    output logic [FRAME_BITS-ID_WIDTH-1:0] cfg,
    output logic                           cfg_loaded,
    output logic                           frame_abort
);

    localparam int               CFG_W    = FRAME_BITS - ID_WIDTH;
    localparam int               CNT_W    = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

    cfg_state_e              state_q, state_d;
    logic [FRAME_BITS-2:0]   sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [CFG_W-1:0]        cfg_d;
    logic                    loaded_d;
    logic                    abort_d;
    logic [FRAME_BITS-1:0]   frame;
    logic                    id_match;

    cfg_chain_pipe u_pipe (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_in_start),
        .cfg_bit   (cfg_bit_in),
        .cfg_valid (cfg_bit_in_valid),
        .fwd_start (cfg_out_start),
        .fwd_bit   (cfg_bit_out),
        .fwd_valid (cfg_bit_out_valid)
    );

    // The oldest shift-register bit is never part of a completed frame, so only the upper
    // FRAME_BITS-1 bits are stored; the incoming bit completes the frame combinationally.
    assign frame    = {cfg_bit_in, sr_q};
    assign id_match = (frame[ID_WIDTH-1:0] == tile_id);

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        cfg_d    = cfg;
        loaded_d = 1'b0;
        abort_d  = 1'b0;
        if (cfg_in_start) begin
            // A start always wins, even over a completing last bit; a same-cycle bit opens the new frame.
            state_d = SHIFT;
            cnt_d   = '0;
            abort_d = (state_q == SHIFT) && (cnt_q != '0);
            if (cfg_bit_in_valid) begin
                sr_d  = frame[FRAME_BITS-1:1];
                cnt_d = CNT_W'(1);
            end
        end else if ((state_q == SHIFT) && cfg_bit_in_valid) begin
            sr_d = frame[FRAME_BITS-1:1];
            if (cnt_q == LAST_BIT) begin
                cnt_d = '0;
                if (id_match) begin
                    cfg_d    = frame[FRAME_BITS-1:ID_WIDTH];
                    loaded_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            cfg         <= '0;
            cfg_loaded  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            cfg         <= cfg_d;
            cfg_loaded  <= loaded_d;
            frame_abort <= abort_d;
        end
    end

endmodule

// File: tb/tb_tile_cfg_deserializer.sv
// Directed bench for tile_cfg_deserializer: expected commits and aborts are queued with their
// cycle when driven, and a per-cycle monitor checks cfg, pulses and chain forwarding against them.
module tb_tile_cfg_deserializer;

    localparam int           FB      = 64;
    localparam int           IDW     = 3;
    localparam int           CW      = FB - IDW;
    localparam logic [2:0]   TILE_ID = 3'b001;

    typedef struct {
        int            cyc;
        logic [CW-1:0] cfg;
    } commit_t;

    logic          clk;
    logic          rst;
    logic [IDW-1:0] tile_id;
    logic          cfg_in_start;
    logic          cfg_bit_in;
    logic          cfg_bit_in_valid;
    logic          cfg_out_start;
    logic          cfg_bit_out;
    logic          cfg_bit_out_valid;
    logic [CW-1:0] cfg;
    logic          cfg_loaded;
    logic          frame_abort;

    commit_t       commit_q[$];
    int            abort_q[$];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    bit            mon_on = 1'b0;
    logic [CW-1:0] exp_cfg = '0;

    localparam logic [FB-1:0] FRAME_A  = 64'hA5A5_0000_0000_0009;
    localparam logic [FB-1:0] FRAME_B  = 64'hFFFF_FFFF_FFFF_FFF9;
    localparam logic [FB-1:0] FRAME_C  = 64'h8000_0000_0000_0011;
    localparam logic [FB-1:0] FRAME_D  = 64'h0123_4567_89AB_CDE9;
    localparam logic [FB-1:0] FRAME_E  = 64'hFFFF_0000_1234_5671;
    localparam logic [FB-1:0] COL0     = {{CW{1'b1}}, 3'b000};
    localparam logic [FB-1:0] COL1     = {61'd5, 3'b001};

    tile_cfg_deserializer dut (
        .clk               (clk),
        .rst               (rst),
        .tile_id           (tile_id),
        .cfg_in_start      (cfg_in_start),
        .cfg_bit_in        (cfg_bit_in),
        .cfg_bit_in_valid  (cfg_bit_in_valid),
        .cfg_out_start     (cfg_out_start),
        .cfg_bit_out       (cfg_bit_out),
        .cfg_bit_out_valid (cfg_bit_out_valid),
        .cfg               (cfg),
        .cfg_loaded        (cfg_loaded),
        .frame_abort       (frame_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic b, input logic v);
        @(negedge clk);
        cfg_in_start     = s;
        cfg_bit_in       = b;
        cfg_bit_in_valid = v;
    endtask

    task automatic start_frame(input bit expect_abort, input logic b, input logic v);
        applyStimulus(1'b1, b, v);
        if (expect_abort) abort_q.push_back(cyc + 1);
    endtask

    // Sends bits lo..hi of f, with gap idle (valid-low, random data) cycles between bits.
    task automatic send_bits(input logic [FB-1:0] f, input int lo, input int hi, input int gap, input bit armed);
        commit_t e;
        for (int i = lo; i <= hi; i++) begin
            applyStimulus(1'b0, f[i], 1'b1);
            if (armed && (i == FB - 1) && (f[IDW-1:0] == TILE_ID)) begin
                e.cyc = cyc + 1;
                e.cfg = f[FB-1:IDW];
                commit_q.push_back(e);
            end
            if (i != hi) repeat (gap) applyStimulus(1'b0, 1'($urandom), 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 1'b0);
    endtask

    task automatic apply_reset(input int n);
        @(negedge clk);
        rst              = 1'b1;
        cfg_in_start     = 1'b0;
        cfg_bit_in       = 1'b0;
        cfg_bit_in_valid = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checkOutput({tag, "_cfg"}, 64'(cfg), 64'h0);
        checkOutput({tag, "_loaded"}, 64'(cfg_loaded), 64'h0);
        checkOutput({tag, "_abort"}, 64'(frame_abort), 64'h0);
        checkOutput({tag, "_out_start"}, 64'(cfg_out_start), 64'h0);
        checkOutput({tag, "_bit_out"}, 64'(cfg_bit_out), 64'h0);
        checkOutput({tag, "_out_valid"}, 64'(cfg_bit_out_valid), 64'h0);
    endtask

    // Per-cycle monitor, sampling 1 time unit after each rising edge.
    initial begin
        logic s_rst, s_start, s_bit, s_valid, exp_loaded, exp_abort;
        forever begin
            @(posedge clk);
            cyc++;
            s_rst   = rst;
            s_start = cfg_in_start;
            s_bit   = cfg_bit_in;
            s_valid = cfg_bit_in_valid;
            #1;
            if (s_rst) mon_on = 1'b1;
            if (mon_on) begin
                exp_loaded = 1'b0;
                exp_abort  = 1'b0;
                if (s_rst) exp_cfg = '0;
                if (commit_q.size() > 0 && commit_q[0].cyc == cyc) begin
                    exp_cfg    = commit_q[0].cfg;
                    exp_loaded = 1'b1;
                    void'(commit_q.pop_front());
                end
                if (abort_q.size() > 0 && abort_q[0] == cyc) begin
                    exp_abort = 1'b1;
                    void'(abort_q.pop_front());
                end
                checkOutput("fwd_start", 64'(cfg_out_start), 64'(s_rst ? 1'b0 : s_start));
                checkOutput("fwd_bit", 64'(cfg_bit_out), 64'(s_rst ? 1'b0 : s_bit));
                checkOutput("fwd_valid", 64'(cfg_bit_out_valid), 64'(s_rst ? 1'b0 : s_valid));
                checkOutput("cfg_loaded", 64'(cfg_loaded), 64'(exp_loaded));
                checkOutput("frame_abort", 64'(frame_abort), 64'(exp_abort));
                checkOutput("cfg", 64'(cfg), 64'(exp_cfg));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tile_id          = TILE_ID;
        rst              = 1'b1;
        cfg_in_start     = 1'b0;
        cfg_bit_in       = 1'b0;
        cfg_bit_in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        $display("[TB] valid bits in IDLE are forwarded only");
        send_bits(FRAME_A, 0, FB - 1, 0, 1'b0);
        idle(3);
        checkOutput("idle_cfg", 64'(cfg), 64'h0);

        $display("[TB] single matching frame");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_A, 0, FB - 1, 0, 1'b1);
        idle(3);
        checkOutput("match_cfg", 64'(cfg), 64'h14B4_A000_0000_0001);

        $display("[TB] column stream, second frame addressed to this tile");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(COL0, 0, FB - 1, 0, 1'b1);
        send_bits(COL1, 0, FB - 1, 0, 1'b1);
        idle(3);
        checkOutput("column_cfg", 64'(cfg), 64'd5);

        $display("[TB] gapped valid, one bit every third cycle");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_A, 0, FB - 1, 2, 1'b1);
        idle(3);
        checkOutput("gapped_cfg", 64'(cfg), 64'h14B4_A000_0000_0001);

        $display("[TB] start after 20 bits aborts the partial frame");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_B, 0, 19, 0, 1'b0);
        start_frame(1'b1, 1'b0, 1'b0);
        send_bits(FRAME_D, 0, FB - 1, 0, 1'b1);
        idle(3);
        checkOutput("abort_cfg", 64'(cfg), 64'(FRAME_D[FB-1:IDW]));

        $display("[TB] reset after 30 bits, then a clean frame");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_A, 0, 29, 0, 1'b0);
        apply_reset(2);
        check_all_zero("midreset");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_E, 0, FB - 1, 0, 1'b1);
        idle(3);
        checkOutput("post_reset_cfg", 64'(cfg), 64'(FRAME_E[FB-1:IDW]));

        $display("[TB] start coincident with the last bit, carrying bit 0 of the next frame");
        start_frame(1'b0, 1'b0, 1'b0);
        send_bits(FRAME_A, 0, FB - 2, 0, 1'b0);
        start_frame(1'b1, FRAME_C[0], 1'b1);
        send_bits(FRAME_C, 1, FB - 1, 0, 1'b1);
        idle(3);
        checkOutput("coincident_cfg", 64'(cfg), 64'(FRAME_C[FB-1:IDW]));

        $display("[TB] trailing partial frame aborted by the next start");
        send_bits(FRAME_B, 0, 4, 0, 1'b0);
        start_frame(1'b1, 1'b0, 1'b0);
        start_frame(1'b0, 1'b0, 1'b0);
        idle(4);
        checkOutput("trailing_cfg", 64'(cfg), 64'(FRAME_C[FB-1:IDW]));

        checkOutput("commit_queue_empty", 64'(commit_q.size()), 64'h0);
        checkOutput("abort_queue_empty", 64'(abort_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_cfg_deserializer.md
Name: tile_cfg_deserializer

Overview:
- Tile-side receiver of the serial configuration chain driven by the Wishbone configuration bridge (cfg_out_start / cfg_bit_out / cfg_bit_out_valid).
- Deserializes LSB-first frames and compares each frame's low ID field against the tile's strapped ID; on a match it commits the payload to the tile's cfg register.
- Forwards every input bit, registered, to the next tile in the column chain.

Parameters:
- ID_WIDTH, 3, width of the per-frame tile ID field (frame bits [ID_WIDTH-1:0]).
- FRAME_BITS, 64, bits per tile frame (tile config size padded to a multiple of 32); must be > ID_WIDTH.
- CFG_W (localparam), FRAME_BITS-ID_WIDTH, payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- tile_id  in  ID_WIDTH  static strap giving this tile's row position.
- cfg_in_start  in  1  one-cycle pulse that opens a new frame sequence.
- cfg_bit_in  in  1  serial data bit.
- cfg_bit_in_valid  in  1  qualifies cfg_bit_in.
- cfg_out_start  out  1  cfg_in_start delayed 1 cycle.
- cfg_bit_out  out  1  cfg_bit_in delayed 1 cycle.
- cfg_bit_out_valid  out  1  cfg_bit_in_valid delayed 1 cycle.
- cfg  out  CFG_W  committed configuration payload (frame bits [FRAME_BITS-1:ID_WIDTH]).
- cfg_loaded  out  1  one-cycle pulse after each commit.
- frame_abort  out  1  one-cycle pulse when a start truncates a partial frame.

Behaviour:
- Reset values: all outputs 0, cfg = 0, sr = 0, bit_cnt = 0, state = IDLE.
- Forwarding: the three cfg_out_* signals are plain registers of the inputs, with a fixed latency of 1. They forward unconditionally in every state, including cycles where this tile commits. They are cleared by rst.
- State machine has two states, IDLE and SHIFT:
  - IDLE: cfg_bit_in_valid is ignored (forwarded only). cfg_in_start moves to SHIFT and sets bit_cnt = 0.
  - SHIFT: on each valid cycle, sr <= {cfg_bit_in, sr[FRAME_BITS-1:1]} and bit_cnt increments. The first received bit therefore ends at sr[0].
- Frame completion: occurs on the cycle in which a valid bit arrives with bit_cnt == FRAME_BITS-1.
  - The assembled frame F = {cfg_bit_in, sr[FRAME_BITS-1:1]}.
  - If F[ID_WIDTH-1:0] == tile_id, then cfg <= F[FRAME_BITS-1:ID_WIDTH] at that edge, and cfg_loaded is high for the following cycle.
  - bit_cnt wraps to 0 and the state stays SHIFT, so back-to-back frames for other tiles are parsed with no gap.
  - A non-matching frame leaves cfg unchanged and does not pulse cfg_loaded.
- Gaps: cycles with valid low hold sr and bit_cnt. There is no timeout.
- Start mid-frame (bit_cnt != 0 in SHIFT): the partial frame is discarded, bit_cnt = 0, frame_abort pulses for the next cycle, and cfg is unchanged.
- Start with valid in the same cycle: the counter is cleared first, then the bit is accepted as bit 0 of the new frame (bit_cnt becomes 1).
- Start coincident with a completing last bit: start wins, the frame is not committed, and frame_abort pulses.
- Reset mid-frame: everything returns to reset values, including cfg = 0.
- The state stays SHIFT until rst. Trailing valid bits accumulate as a harmless partial frame that the next start aborts (frame_abort pulses only if bit_cnt != 0).
- Widths: bit_cnt is $clog2(FRAME_BITS) bits; the comparison against FRAME_BITS-1 is exact.

Decomposition:
- Shared cfg package/header holds ID_WIDTH, FRAME_BITS (derived from CFG_SIZE rounded up to 32), and state encodings IDLE = 1'b0, SHIFT = 1'b1.
- The block is implemented as one module. An optional sub-module, cfg_chain_pipe, holds the 3-bit forwarding register stage so that it can be reused by IO tiles.

Test Plan (FRAME_BITS=64, ID_WIDTH=3, tile_id=3'b001):
- Matching frame: start, then 64 valid bits of 64'hA5A5_0000_0000_0009 sent LSB first. Expected: cfg = 61'h14B4_A000_0000_0001 one edge after the last bit; cfg_loaded pulses exactly once; cfg_out_* equal the inputs delayed by 1 cycle on every cycle.
- Column stream: start, then frame ID 000 (payload all ones), then frame ID 001 (payload 0x5). Expected: only the second frame is committed; cfg = 5; a single cfg_loaded pulse.
- Gapped valid (valid high every third cycle) for a matching frame. Expected: the same cfg as the ungapped case, with the commit on the edge of the 64th valid bit.
- Abort: start, 20 bits, start, then a full matching frame. Expected: frame_abort pulses once, 1 cycle after the second start; cfg reflects only the second frame.
- Reset mid-frame: rst high after 30 bits of a matching frame. Expected: cfg = 0, all outputs 0, and a subsequent clean frame commits correctly.
- Valid in IDLE: 64 valid bits without a start. Expected: no cfg change and no cfg_loaded; the bits still appear on cfg_bit_out with 1-cycle latency.
